// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle RV32I controller and its datapath.
// The master (controller) drives the datapath strobes and samples IR and memory status.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [2:0]  imm_type;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        trap;

  // mem_req is a request held high until mem_ready is seen in the same cycle;
  // the access completes in exactly the cycle where both are 1.
  modport master (
    input  instr, branch_taken, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, imm_type,
           alu_a_sel, alu_b_sel, rf_we, wb_sel, trap
  );

  modport slave (
    output instr, branch_taken, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, imm_type,
           alu_a_sel, alu_b_sel, rf_we, wb_sel, trap
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared datapath, counts retired instructions and traps on illegal opcodes or memory timeouts.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic [6:0] opcode;
  logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, legal;
  logic [2:0] imm_type;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, trap, retire;
  logic       alu_a_sel, alu_b_sel;
  logic [1:0] pc_sel, wb_sel;
  logic       unused_instr_bits;

  assign opcode            = bus.instr[6:0];
  assign unused_instr_bits = ^bus.instr[31:7];

  always_comb begin
    is_r     = (opcode == 7'b0110011);
    is_i     = (opcode == 7'b0010011);
    is_ld    = (opcode == 7'b0000011);
    is_st    = (opcode == 7'b0100011);
    is_br    = (opcode == 7'b1100011);
    is_jal   = (opcode == 7'b1101111);
    is_jalr  = (opcode == 7'b1100111);
    is_lui   = (opcode == 7'b0110111);
    is_auipc = (opcode == 7'b0010111);
    legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;

    imm_type = 3'd7;
    if (is_i || is_ld || is_jalr) imm_type = 3'd0;
    else if (is_st)               imm_type = 3'd1;
    else if (is_br)               imm_type = 3'd2;
    else if (is_lui || is_auipc)  imm_type = 3'd3;
    else if (is_jal)              imm_type = 3'd4;
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 2'b00;
    trap         = 1'b0;
    retire       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_MAX) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        alu_a_sel = is_auipc;
        alu_b_sel = is_i | is_ld | is_st | is_jalr | is_auipc;
        if (is_br) begin
          pc_we   = 1'b1;
          pc_sel  = bus.branch_taken ? 2'b01 : 2'b00;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_st;
        if (bus.mem_ready) begin
          if (is_st) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_MAX) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        if (is_ld) wb_sel = 2'b01;
        else if (is_jal || is_jalr) wb_sel = 2'b10;
        else if (is_lui) wb_sel = 2'b11;
        if (is_jal) pc_sel = 2'b01;
        else if (is_jalr) pc_sel = 2'b10;
      end
      S_TRAP:  trap = 1'b1;
      default: state_d = S_TRAP;
    endcase

    // The wait counter only runs while parked in a memory-request state.
    if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q) wait_d = wait_q + 1'b1;
    else wait_d = '0;

    instret_d = retire ? instret_q + 1'b1 : instret_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  // Reset forces every output low, aborting any in-flight strobe in the reset cycle.
  assign bus.mem_req      = mem_req & ~rst;
  assign bus.mem_we       = mem_we & ~rst;
  assign bus.mem_addr_sel = mem_addr_sel & ~rst;
  assign bus.ir_we        = ir_we & ~rst;
  assign bus.pc_we        = pc_we & ~rst;
  assign bus.pc_sel       = rst ? 2'b00 : pc_sel;
  assign bus.imm_type     = rst ? 3'd0 : imm_type;
  assign bus.alu_a_sel    = alu_a_sel & ~rst;
  assign bus.alu_b_sel    = alu_b_sel & ~rst;
  assign bus.rf_we        = rf_we & ~rst;
  assign bus.wb_sel       = rst ? 2'b00 : wb_sel;
  assign bus.trap         = trap & ~rst;
  assign state_o          = rst ? 3'd0 : state_q;
  assign instret          = rst ? '0 : instret_q;

endmodule
